// File: rtl/tsv_fault_scan_if.sv
// TSV self-test bundle: scan handshake, TSV mux control/pattern,
// loopback receive bits and the faulty-TSV flag result.
interface tsv_fault_scan_if #(
    parameter int NTSV = 5
);
    localparam int CW = $clog2(NTSV + 1);

    logic            start;
    logic            busy;
    logic            done;
    logic            tsv_drv_en;
    logic [NTSV-1:0] tsv_drv;
    logic [NTSV-1:0] tsv_rx;
    logic [NTSV-1:0] f_flag;
    logic [CW-1:0]   fault_cnt;
    logic            flag_valid;

    modport master (
        input  start,
        input  tsv_rx,
        output busy,
        output done,
        output tsv_drv_en,
        output tsv_drv,
        output f_flag,
        output fault_cnt,
        output flag_valid
    );

    modport slave (
        output start,
        output tsv_rx,
        input  busy,
        input  done,
        input  tsv_drv_en,
        input  tsv_drv,
        input  f_flag,
        input  fault_cnt,
        input  flag_valid
    );
endinterface

// File: rtl/tsv_fault_scan.sv
// TSV built-in self-test: all-0, all-1 and walking-1 patterns, loopback
// compare, faulty-TSV flags. TSV_SCAN_STICKY_EN: flags accumulate until reset.
module tsv_fault_scan #(
    parameter int NTSV       = 5,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clock,
    input  logic              reset,
    tsv_fault_scan_if.master  bus
);
    localparam int NPH = NTSV + 2;
    localparam int PW  = $clog2(NPH);
    localparam int CW  = $clog2(NTSV + 1);
    localparam int SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [NTSV-1:0] acc_q, acc_d;

    logic            busy_d;
    logic            done_d;
    logic            en_d;
    logic [NTSV-1:0] drv_d;
    logic [NTSV-1:0] flag_d;
    logic [CW-1:0]   cnt_d;
    logic            valid_d;
    logic [NTSV-1:0] sample;
    logic [NTSV-1:0] merged;

    function automatic logic [NTSV-1:0] pattern(input logic [PW-1:0] p);
        logic [NTSV-1:0] one;
        logic [NTSV-1:0] pat;
        one = {{(NTSV-1){1'b0}}, 1'b1};
        unique case (1'b1)
            (p == '0):      pat = '0;
            (p == PW'(1)):  pat = '1;
            default:        pat = one << (p - PW'(2));
        endcase
        return pat;
    endfunction

    function automatic logic [CW-1:0] popcnt(input logic [NTSV-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NTSV; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Next-state and next-output decode for the scan sequencer
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        settle_d = settle_q;
        acc_d    = acc_q;
        busy_d   = bus.busy;
        done_d   = 1'b0;
        en_d     = bus.tsv_drv_en;
        drv_d    = bus.tsv_drv;
        flag_d   = bus.f_flag;
        cnt_d    = bus.fault_cnt;
        valid_d  = bus.flag_valid;
        sample   = '0;
        merged   = '0;

        unique case (state_q)
            // The done cycle behaves as idle so scans can run back to back
            IDLE, FINISH: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d  = DRIVE;
                    phase_d  = '0;
                    settle_d = SW'(SETTLE_CYC - 1);
                    acc_d    = '0;
                    busy_d   = 1'b1;
                    en_d     = 1'b1;
                    drv_d    = pattern('0);
                end
            end
            DRIVE: begin
                if (settle_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            SAMPLE: begin
                sample = acc_q | (bus.tsv_rx ^ bus.tsv_drv);
                acc_d  = sample;
                if (phase_q == PW'(NPH - 1)) begin
`ifdef TSV_SCAN_STICKY_EN
                    merged = bus.f_flag | sample;
`else
                    merged = sample;
`endif
                    state_d = FINISH;
                    flag_d  = merged;
                    cnt_d   = popcnt(merged);
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    en_d    = 1'b0;
                    drv_d   = '0;
                end else begin
                    state_d  = DRIVE;
                    phase_d  = phase_q + PW'(1);
                    settle_d = SW'(SETTLE_CYC - 1);
                    drv_d    = pattern(phase_q + PW'(1));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, accumulator and registered outputs; reset discards a partial scan
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            settle_q       <= '0;
            acc_q          <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.tsv_drv_en <= 1'b0;
            bus.tsv_drv    <= '0;
            bus.f_flag     <= '0;
            bus.fault_cnt  <= '0;
            bus.flag_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            settle_q       <= settle_d;
            acc_q          <= acc_d;
            bus.busy       <= busy_d;
            bus.done       <= done_d;
            bus.tsv_drv_en <= en_d;
            bus.tsv_drv    <= drv_d;
            bus.f_flag     <= flag_d;
            bus.fault_cnt  <= cnt_d;
            bus.flag_valid <= valid_d;
        end
    end
endmodule

// File: tb/tb_tsv_fault_scan.sv
// Directed bench for tsv_fault_scan: loopback fault models, scoreboard of
// expected flag vectors checked on each done pulse.
module tb_tsv_fault_scan;
    localparam int NTSV = 5;

    typedef struct packed {
        logic [4:0] flag;
        logic [2:0] cnt;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic [4:0] s0_mask;
    logic [4:0] s1_mask;
    logic [4:0] br_mask;
    logic [4:0] model_flag;
    bit         sticky;

    tsv_fault_scan_if #(.NTSV(NTSV)) bus ();

    tsv_fault_scan #(
        .NTSV       (NTSV),
        .SETTLE_CYC (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Far-end loopback with stuck-at and wired-OR bridge faults
    always_comb begin
        logic [4:0] rx;
        rx = (bus.tsv_drv & ~s0_mask) | s1_mask;
        if ((bus.tsv_drv & br_mask) != 5'b0) rx = rx | br_mask;
        bus.tsv_rx = rx;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] pat(input int p);
        logic [4:0] one;
        one = 5'd1;
        if (p == 0) return 5'b00000;
        if (p == 1) return 5'b11111;
        return one << (p - 2);
    endfunction

    function automatic exp_t expect_for(input logic [4:0] raw);
        exp_t e;
        e.flag = sticky ? (model_flag | raw) : raw;
        e.cnt  = 3'($countones(e.flag));
        return e;
    endfunction

    task automatic set_faults(input logic [4:0] s0, input logic [4:0] s1,
                              input logic [4:0] br);
        s0_mask = s0;
        s1_mask = s1;
        br_mask = br;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_flag = 5'b0;
    endtask

    task automatic run_scan(input string tag, input logic [4:0] raw,
                            input bit extra);
        exp_t e;
        int   m;
        bit   seen;
        bit   busy_ok;
        logic [4:0] prev;
        prev = model_flag;
        sb.push_back(expect_for(raw));
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        m = 0;
        seen = 0;
        busy_ok = 1;
        while (!seen && m < 40) begin
            if (bus.done === 1'b1) begin
                seen = 1;
            end else begin
                if (bus.busy !== 1'b1) busy_ok = 0;
                if ((m % 3) == 2 && m < 21) begin
                    chk({tag, " drv"}, 32'(bus.tsv_drv), 32'(pat((m - 2) / 3)));
                end
                if (m == 10) begin
                    chk({tag, " drv_en"}, 32'(bus.tsv_drv_en), 32'd1);
                    chk({tag, " flag_hold"}, 32'(bus.f_flag), 32'(prev));
                end
                if (extra && m == 4) bus.start = 1'b1;
                if (extra && m == 5) bus.start = 1'b0;
                @(negedge clock);
                m++;
            end
        end
        chk({tag, " done_latency"}, 32'(m), 32'd21);
        chk({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        e = sb.pop_front();
        if (seen) begin
            chk({tag, " f_flag"}, 32'(bus.f_flag), 32'(e.flag));
            chk({tag, " fault_cnt"}, 32'(bus.fault_cnt), 32'(e.cnt));
            chk({tag, " flag_valid"}, 32'(bus.flag_valid), 32'd1);
            chk({tag, " busy_end"}, 32'(bus.busy), 32'd0);
            chk({tag, " drv_en_end"}, 32'(bus.tsv_drv_en), 32'd0);
            chk({tag, " drv_end"}, 32'(bus.tsv_drv), 32'd0);
            @(negedge clock);
            chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        end
        model_flag = e.flag;
    endtask

    initial begin
        int   m;
        int   d0;
        int   d1;
        int   ndone;
        bit   no_done;
        exp_t e;

        checks = 0;
        errors = 0;
`ifdef TSV_SCAN_STICKY_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        model_flag = 5'b0;
        set_faults(5'b0, 5'b0, 5'b0);
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst drv_en", 32'(bus.tsv_drv_en), 32'd0);
        chk("rst drv", 32'(bus.tsv_drv), 32'd0);
        chk("rst f_flag", 32'(bus.f_flag), 32'd0);
        chk("rst cnt", 32'(bus.fault_cnt), 32'd0);
        chk("rst valid", 32'(bus.flag_valid), 32'd0);
        reset = 1'b0;

        run_scan("clean", 5'b00000, 1'b1);

        set_faults(5'b00100, 5'b0, 5'b0);
        run_scan("stuck0_b2", 5'b00100, 1'b0);

        set_faults(5'b0, 5'b0, 5'b0);
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_flag = 5'b0;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst drv_en", 32'(bus.tsv_drv_en), 32'd0);
        chk("midrst drv", 32'(bus.tsv_drv), 32'd0);
        chk("midrst f_flag", 32'(bus.f_flag), 32'd0);
        chk("midrst cnt", 32'(bus.fault_cnt), 32'd0);
        chk("midrst valid", 32'(bus.flag_valid), 32'd0);
        no_done = 1;
        for (int i = 0; i < 30; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 0;
            @(negedge clock);
        end
        chk("midrst no_done", 32'(no_done), 32'd1);

        set_faults(5'b0, 5'b0, 5'b01010);
        run_scan("bridge_1_3", 5'b01010, 1'b0);

        do_reset();
        set_faults(5'b0, 5'b00001, 5'b0);
        run_scan("sticky_s1", 5'b00001, 1'b0);
        set_faults(5'b0, 5'b0, 5'b0);
        run_scan("sticky_s2", 5'b00000, 1'b0);

        sb.push_back(expect_for(5'b00000));
        sb.push_back(expect_for(5'b00000));
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        d0 = -1;
        d1 = -1;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            m = i;
            if (m == 43) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                if (ndone == 0) d0 = m;
                if (ndone == 1) d1 = m;
                ndone++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("b2b f_flag", 32'(bus.f_flag), 32'(e.flag));
                    model_flag = e.flag;
                end
            end
        end
        bus.start = 1'b0;
        chk("b2b ndone", 32'(ndone), 32'd2);
        chk("b2b done0", 32'(d0), 32'd21);
        chk("b2b done1", 32'(d1), 32'd43);
        chk("b2b idle", 32'(bus.busy), 32'd0);
        chk("sb empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
